// File: rtl/dram_init_checker_pkg.sv
// Shared constants for the bucket-header init checker: DDR3 command
// codes, header field layout, bucket stride and ORAM tree sizing.
package dram_init_checker_pkg;

    localparam logic [2:0] Ddr3CmdWrite = 3'b000;
    localparam logic [2:0] Ddr3CmdRead  = 3'b001;

    localparam logic [63:0] IvInitDefault = 64'h0;

    // Header layout: IV at the bottom, valid bits above it,
    // everything from HdrSpaceLo upward is don't-care.
    localparam int HdrIvLo      = 0;
    localparam int HdrIvWidth   = 64;
    localparam int HdrValidLo   = HdrIvLo + HdrIvWidth;
    localparam int HdrValidBits = 4;
    localparam int HdrSpaceLo   = HdrValidLo + HdrValidBits;

    localparam int BktSizeDrWords = 8;

    // Tree buckets plus one spare bucket per subtree.
    function automatic int numBucketsFor(int levels, int subtrees);
        return (1 << (levels + 1)) + subtrees;
    endfunction

    // Counter width able to hold the value n itself.
    function automatic int cntWidth(int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dram_init_checker_if.sv
// DRAM command / read-data port used by the init checker.
// master: checker side (drives commands, accepts beats); slave: DRAM side.
interface dram_init_checker_if
    import dram_init_checker_pkg::*;
#(
    parameter int DDRAWidth = 30,
    parameter int DDRCWidth = 3,
    parameter int BEDWidth  = 128
);
    logic [DDRAWidth-1:0] DRAMCommandAddress;
    logic [DDRCWidth-1:0] DRAMCommand;
    logic                 DRAMCommandValid;
    logic                 DRAMCommandReady;
    logic [BEDWidth-1:0]  DRAMReadData;
    logic                 DRAMReadDataValid;
    logic                 DRAMReadDataReady;

    modport master (
        output DRAMCommandAddress,
        output DRAMCommand,
        output DRAMCommandValid,
        input  DRAMCommandReady,
        input  DRAMReadData,
        input  DRAMReadDataValid,
        output DRAMReadDataReady
    );

    modport slave (
        input  DRAMCommandAddress,
        input  DRAMCommand,
        input  DRAMCommandValid,
        output DRAMCommandReady,
        output DRAMReadData,
        output DRAMReadDataValid,
        input  DRAMReadDataReady
    );
endinterface

// File: rtl/dram_init_checker_hdr_beat_assembler.sv
// Collects BEDWidth read beats into one DDRDWidth header, LSB chunk first.
// Ports: Clock, Reset (async low), BeatValid/BeatData in; HeaderValid/Header
// out, valid combinationally on the last beat (held beats + current beat).
module hdr_beat_assembler
    import dram_init_checker_pkg::*;
#(
    parameter int DDRDWidth = 512,
    parameter int BEDWidth  = 128
)(
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 BeatValid,
    input  logic [BEDWidth-1:0]  BeatData,
    output logic                 HeaderValid,
    output logic [DDRDWidth-1:0] Header
);
    localparam int Beats =
        (BEDWidth >= DDRDWidth) ? 1 : DDRDWidth / BEDWidth;

    generate
        if (Beats == 1) begin : gOne
            assign HeaderValid = BeatValid;
            if (BEDWidth > DDRDWidth) begin : gWide
                logic unusedHi;
                assign Header   = BeatData[DDRDWidth-1:0];
                assign unusedHi = ^BeatData[BEDWidth-1:DDRDWidth];
            end else begin : gExact
                assign Header = BeatData;
            end
        end else begin : gMulti
            localparam int CntW = $clog2(Beats);
            localparam logic [CntW-1:0] LastIdx = CntW'(Beats - 1);

            logic [CntW-1:0]     beatCnt;
            logic [BEDWidth-1:0] held [Beats];
            logic                lastBeat;

            assign lastBeat    = beatCnt == LastIdx;
            assign HeaderValid = BeatValid & lastBeat;

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    beatCnt <= '0;
                    held    <= '{default: '0};
                end else if (BeatValid) begin
                    held[beatCnt] <= BeatData;
                    beatCnt <= lastBeat ? '0 : beatCnt + 1'b1;
                end
            end

            always_comb begin
                Header = '0;
                for (int k = 0; k < Beats - 1; k++)
                    Header[k*BEDWidth +: BEDWidth] = held[k];
                Header[(Beats-1)*BEDWidth +: BEDWidth] = BeatData;
            end
        end
    endgenerate

endmodule

// File: rtl/dram_init_checker.sv
// Reads back every bucket header after init and checks valid bits == 0
// and IV == IVInit. Ports: Clock, Reset (async low), Start; dram (master
// DRAM cmd/read port); Done, Pass, ErrorCount, FirstErrorValid/Bucket.
module dram_init_checker
    import dram_init_checker_pkg::*;
#(
    parameter int DDRAWidth       = 30,
    parameter int DDRCWidth       = 3,
    parameter int DDRDWidth       = 512,
    parameter int BEDWidth        = 128,
    parameter int BktSize_DRWords = BktSizeDrWords,
    parameter int NumBuckets      = numBucketsFor(8, 512),
    parameter int IVWidth         = HdrIvWidth,
    parameter int ValidBits       = HdrValidBits,
    parameter logic [IVWidth-1:0] IVInit = IVWidth'(IvInitDefault),
    parameter logic [DDRCWidth-1:0] DDR3CMD_Read = DDRCWidth'(Ddr3CmdRead),
    parameter int MaxOutstanding  = 8,
    localparam int CntWidth       = cntWidth(NumBuckets)
)(
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    dram_init_checker_if.master dram,
    output logic                Done,
    output logic                Pass,
    output logic [15:0]         ErrorCount,
    output logic                FirstErrorValid,
    output logic [CntWidth-1:0] FirstErrorBucket
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam int OutWidth = $clog2(MaxOutstanding + 1);
    localparam int HdrUsed  = IVWidth + ValidBits;
    localparam logic [CntWidth-1:0]  LastBkt  = CntWidth'(NumBuckets);
    localparam logic [OutWidth-1:0]  OutCap   = OutWidth'(MaxOutstanding);
    localparam logic [DDRAWidth-1:0] AddrStep = DDRAWidth'(BktSize_DRWords);

    logic [1:0]           state;
    logic                 started;
    logic [CntWidth-1:0]  cmdCnt;
    logic [CntWidth-1:0]  chkCnt;
    logic [DDRAWidth-1:0] cmdAddr;
    logic [OutWidth-1:0]  outstanding;
    logic [15:0]          errCnt;
    logic                 firstErrValid;
    logic [CntWidth-1:0]  firstErrBkt;

    logic                 run;
    logic                 cmdValid;
    logic                 cmdFire;
    logic                 rdReady;
    logic                 beatKeep;
    logic                 hdrValid;
    logic                 hdrBad;
    logic [DDRDWidth-1:0] header;

    assign run      = state == StRun;
    assign cmdValid = started & run & (cmdCnt != LastBkt)
                    & (outstanding < OutCap);
    assign cmdFire  = cmdValid & dram.DRAMCommandReady;
    assign rdReady  = started & run;
    // Beats with nothing outstanding are stale (e.g. from before a reset):
    // accept them but keep them out of the assembler.
    assign beatKeep = dram.DRAMReadDataValid & rdReady
                    & (outstanding != '0);

    assign dram.DRAMCommandAddress = cmdAddr;
    assign dram.DRAMCommand        = DDR3CMD_Read;
    assign dram.DRAMCommandValid   = cmdValid;
    assign dram.DRAMReadDataReady  = rdReady;

    hdr_beat_assembler #(
        .DDRDWidth (DDRDWidth),
        .BEDWidth  (BEDWidth)
    ) uAsm (
        .Clock       (Clock),
        .Reset       (Reset),
        .BeatValid   (beatKeep),
        .BeatData    (dram.DRAMReadData),
        .HeaderValid (hdrValid),
        .Header      (header)
    );

    assign hdrBad = (header[IVWidth-1:0] != IVInit)
                  || (header[HdrUsed-1:IVWidth] != '0);

    generate
        if (HdrUsed < DDRDWidth) begin : gSpare
            logic unusedSpare;
            assign unusedSpare = ^header[DDRDWidth-1:HdrUsed];
        end
    endgenerate

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state         <= StRun;
            started       <= 1'b0;
            cmdCnt        <= '0;
            chkCnt        <= '0;
            cmdAddr       <= '0;
            outstanding   <= '0;
            errCnt        <= '0;
            firstErrValid <= 1'b0;
            firstErrBkt   <= '0;
        end else begin
            started <= 1'b1;
            unique case (1'b1)
                state == StRun: begin
                    if (cmdFire) begin
                        cmdCnt  <= cmdCnt + 1'b1;
                        cmdAddr <= cmdAddr + AddrStep;
                    end
                    unique case ({cmdFire, hdrValid})
                        2'b10:   outstanding <= outstanding + 1'b1;
                        2'b01:   outstanding <= outstanding - 1'b1;
                        default: ;
                    endcase
                    if (hdrValid) begin
                        chkCnt <= chkCnt + 1'b1;
                        if (hdrBad) begin
                            if (errCnt != 16'hFFFF)
                                errCnt <= errCnt + 1'b1;
                            if (!firstErrValid) begin
                                firstErrValid <= 1'b1;
                                firstErrBkt   <= chkCnt;
                            end
                        end
                    end
                    if (chkCnt == LastBkt)
                        state <= StDone;
                end
                state == StDone: begin
                    if (Start) begin
                        state         <= StRun;
                        cmdCnt        <= '0;
                        chkCnt        <= '0;
                        cmdAddr       <= '0;
                        outstanding   <= '0;
                        errCnt        <= '0;
                        firstErrValid <= 1'b0;
                        firstErrBkt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Done             = state == StDone;
    assign Pass             = Done & (errCnt == '0);
    assign ErrorCount       = errCnt;
    assign FirstErrorValid  = firstErrValid;
    assign FirstErrorBucket = firstErrBkt;

endmodule

// File: tb/tb_dram_init_checker.sv
// Directed bench for dram_init_checker with a small in-order DRAM model.
// Ports of the DUT are all driven/observed here through dramIf.
module tb_dram_init_checker;
    import dram_init_checker_pkg::*;

    localparam int NB = 16;
    localparam int CW = cntWidth(NB);

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          Start = 1'b0;
    logic          Done;
    logic          Pass;
    logic [15:0]   ErrorCount;
    logic          FirstErrorValid;
    logic [CW-1:0] FirstErrorBucket;

    int compared   = 0;
    int mismatched = 0;

    // model controls (written by stimulus only)
    int readyMode = 0;   // 0: ready, 1: random, 2: never
    int allowHdrs = 1000;
    int maxCmds   = 1000;
    int corruptV  = -1;
    int corruptIv = -1;
    bit gapMode   = 0;
    bit staleMode = 0;

    // model state (written by model only)
    int numIssued = 0;
    int hdrCnt    = 0;
    int addrErr   = 0;
    int stabErr   = 0;
    int beatIdx   = 0;
    int q[$];
    bit prevPend  = 0;
    logic [29:0]  prevAddr = '0;
    logic [511:0] mHdr;

    dram_init_checker_if #(
        .DDRAWidth(30), .DDRCWidth(3), .BEDWidth(128)
    ) dramIf ();

    dram_init_checker #(
        .DDRAWidth(30), .DDRCWidth(3), .DDRDWidth(512),
        .BEDWidth(128), .BktSize_DRWords(8), .NumBuckets(NB),
        .MaxOutstanding(8)
    ) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .Start            (Start),
        .dram             (dramIf),
        .Done             (Done),
        .Pass             (Pass),
        .ErrorCount       (ErrorCount),
        .FirstErrorValid  (FirstErrorValid),
        .FirstErrorBucket (FirstErrorBucket)
    );

    always #5 Clock = ~Clock;

    function automatic logic [511:0] hdrOf(int b);
        logic [511:0] h;
        h = {16{32'hA5C3_3C5A}};
        h[63:0]  = (b == corruptIv) ? 64'h0123_4567_89AB_CDEF : 64'h0;
        h[67:64] = (b == corruptV) ? 4'b0010 : 4'b0000;
        return h;
    endfunction

    // DRAM model: drives at negedge+1, records handshakes at negedge+2
    // (they complete at the following posedge).
    initial begin
        dramIf.DRAMCommandReady  = 1'b0;
        dramIf.DRAMReadDataValid = 1'b0;
        dramIf.DRAMReadData      = '0;
        forever begin
            @(negedge Clock);
            #1;
            if (!Reset || (Start && Done)) begin
                q.delete();
                beatIdx = 0; numIssued = 0; hdrCnt = 0;
                addrErr = 0; stabErr = 0; prevPend = 0;
            end
            if (readyMode == 0)
                dramIf.DRAMCommandReady = numIssued < maxCmds;
            else if (readyMode == 1)
                dramIf.DRAMCommandReady = (numIssued < maxCmds)
                    && ($urandom_range(0, 1) == 1);
            else
                dramIf.DRAMCommandReady = 1'b0;
            if (staleMode) begin
                dramIf.DRAMReadDataValid = 1'b1;
                dramIf.DRAMReadData      = '1;
            end else if (q.size() > 0 && hdrCnt < allowHdrs
                         && (!gapMode || $urandom_range(0, 2) != 0)) begin
                mHdr = hdrOf(q[0]);
                dramIf.DRAMReadDataValid = 1'b1;
                dramIf.DRAMReadData      = mHdr[beatIdx*128 +: 128];
            end else begin
                dramIf.DRAMReadDataValid = 1'b0;
                dramIf.DRAMReadData      = '0;
            end
            #1;
            if (prevPend && !(dramIf.DRAMCommandValid
                && dramIf.DRAMCommandAddress == prevAddr))
                stabErr++;
            prevPend = dramIf.DRAMCommandValid && !dramIf.DRAMCommandReady;
            prevAddr = dramIf.DRAMCommandAddress;
            if (dramIf.DRAMCommandValid && dramIf.DRAMCommandReady) begin
                if (dramIf.DRAMCommandAddress != 30'(numIssued * 8))
                    addrErr++;
                q.push_back(int'(dramIf.DRAMCommandAddress >> 3));
                numIssued++;
            end
            if (dramIf.DRAMReadDataValid && dramIf.DRAMReadDataReady
                && !staleMode) begin
                beatIdx++;
                if (beatIdx == 4) begin
                    beatIdx = 0;
                    void'(q.pop_front());
                    hdrCnt++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulseStart();
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n;
        n = 0;
        while (Done !== 1'b1 && n < budget) begin
            @(negedge Clock);
            n++;
        end
        chk(tag, Done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset values
        repeat (3) @(negedge Clock);
        chk("rst_done", Done, 0);
        chk("rst_pass", Pass, 0);
        chk("rst_err", ErrorCount, 0);
        chk("rst_fev", FirstErrorValid, 0);
        chk("rst_feb", FirstErrorBucket, 0);
        chk("rst_cmdv", dramIf.DRAMCommandValid, 0);
        chk("rst_rdy", dramIf.DRAMReadDataReady, 0);

        // T1: autostart, clean pass
        Reset = 1'b1;
        #1;
        chk("t1_cmdv_first", dramIf.DRAMCommandValid, 0);
        chk("t1_rdy_first", dramIf.DRAMReadDataReady, 0);
        @(negedge Clock);
        chk("t1_cmdv", dramIf.DRAMCommandValid, 1);
        chk("t1_rdy", dramIf.DRAMReadDataReady, 1);
        chk("t1_cmd", dramIf.DRAMCommand, Ddr3CmdRead);
        chk("t1_addr0", dramIf.DRAMCommandAddress, 0);
        waitDone("t1_done", 400);
        chk("t1_issued", numIssued, NB);
        chk("t1_addrerr", addrErr, 0);
        chk("t1_hdrs", hdrCnt, NB);
        chk("t1_pass", Pass, 1);
        chk("t1_err", ErrorCount, 0);
        chk("t1_fev", FirstErrorValid, 0);
        chk("t1_idlecmd", dramIf.DRAMCommandValid, 0);

        // T2: bucket 5 bad valid bits, bucket 9 bad IV
        corruptV  = 5;
        corruptIv = 9;
        pulseStart();
        waitDone("t2_done", 400);
        chk("t2_err", ErrorCount, 2);
        chk("t2_fev", FirstErrorValid, 1);
        chk("t2_feb", FirstErrorBucket, 5);
        chk("t2_pass", Pass, 0);

        // T3: restart clears, bucket 3 bad
        corruptV  = 3;
        corruptIv = -1;
        pulseStart();
        chk("t3_clr_done", Done, 0);
        chk("t3_clr_err", ErrorCount, 0);
        chk("t3_clr_fev", FirstErrorValid, 0);
        chk("t3_clr_feb", FirstErrorBucket, 0);
        waitDone("t3_done", 400);
        chk("t3_err", ErrorCount, 1);
        chk("t3_feb", FirstErrorBucket, 3);
        chk("t3_issued", numIssued, NB);

        // T4: withheld data caps outstanding at 8
        corruptV  = -1;
        allowHdrs = 0;
        pulseStart();
        repeat (30) @(negedge Clock);
        chk("t4_cap", numIssued, 8);
        chk("t4_cap_v", dramIf.DRAMCommandValid, 0);
        allowHdrs = 1;
        repeat (30) @(negedge Clock);
        chk("t4_one_more", numIssued, 9);
        chk("t4_hdrs", hdrCnt, 1);
        chk("t4_cap_v2", dramIf.DRAMCommandValid, 0);
        allowHdrs = 1000;
        waitDone("t4_done", 400);
        chk("t4_pass", Pass, 1);
        chk("t4_issued", numIssued, NB);
        chk("t4_addrerr", addrErr, 0);

        // T5: random backpressure and gaps, bucket 11 bad
        readyMode = 1;
        gapMode   = 1;
        corruptV  = 11;
        pulseStart();
        waitDone("t5_done", 2000);
        chk("t5_stable", stabErr, 0);
        chk("t5_issued", numIssued, NB);
        chk("t5_addrerr", addrErr, 0);
        chk("t5_hdrs", hdrCnt, NB);
        chk("t5_err", ErrorCount, 1);
        chk("t5_feb", FirstErrorBucket, 11);

        // T6: async reset with 5 reads in flight, stale beats after
        readyMode = 0;
        gapMode   = 0;
        corruptV  = -1;
        allowHdrs = 0;
        maxCmds   = 5;
        pulseStart();
        repeat (20) @(negedge Clock);
        chk("t6_inflight", numIssued, 5);
        chk("t6_cmdv_pre", dramIf.DRAMCommandValid, 1);
        #3 Reset = 1'b0;
        #1;
        chk("t6_async_cmdv", dramIf.DRAMCommandValid, 0);
        chk("t6_async_rdy", dramIf.DRAMReadDataReady, 0);
        chk("t6_async_done", Done, 0);
        staleMode = 1;
        readyMode = 2;
        maxCmds   = 1000;
        allowHdrs = 1000;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        repeat (8) @(negedge Clock);
        chk("t6_stale_err", ErrorCount, 0);
        chk("t6_stale_fev", FirstErrorValid, 0);
        chk("t6_stale_done", Done, 0);
        chk("t6_stale_addr", dramIf.DRAMCommandAddress, 0);
        staleMode = 0;
        readyMode = 0;
        waitDone("t6_done", 400);
        chk("t6_pass", Pass, 1);
        chk("t6_issued", numIssued, NB);
        chk("t6_addrerr", addrErr, 0);
        chk("t6_stable", stabErr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dram_init_checker.md
Name: dram_init_checker

Overview:
- Read-side counterpart of the bucket-header initializer.
- After the initializer finishes, this block reads back the header burst of every bucket in the ORAM tree and checks that the valid bits are all zero and the IV field equals the init IV.
- It reports pass/fail, an error count and the first failing bucket.
- It sits on the DRAM command/read-data port during bring-up, before the first ORAM access.

Parameters:
- DDRAWidth, 30, DRAM burst address width.
- DDRCWidth, 3, DRAM command width.
- DDRDWidth, 512, DRAM burst (header word) width.
- BEDWidth, 128, read-data beat width; must divide DDRDWidth, or be >= DDRDWidth.
- BktSize_DRWords, 8, bucket stride in DRAM bursts.
- NumBuckets, 1024, buckets to check (tree buckets plus one spare per subtree).
- IVWidth, 64, IV field width, header bits [IVWidth-1:0].
- ValidBits, 4, valid field width, header bits [IVWidth+ValidBits-1:IVWidth].
- IVInit, 64'h0, expected IV.
- DDR3CMD_Read, 3'b001, read command encoding.
- MaxOutstanding, 8, cap on issued-but-unreturned header reads.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset (asserted at 0).
- Start  in  1  pulse: begin a check pass; ignored while RUN.
- DRAMCommandAddress  out  DDRAWidth  burst address of the header being read.
- DRAMCommand  out  DDRCWidth  always DDR3CMD_Read.
- DRAMCommandValid  out  1  command request.
- DRAMCommandReady  in  1  command accepted when Valid & Ready.
- DRAMReadData  in  BEDWidth  read-data beat.
- DRAMReadDataValid  in  1  beat valid.
- DRAMReadDataReady  out  1  beat accept.
- Done  out  1  pass complete.
- Pass  out  1  Done and ErrorCount==0.
- ErrorCount  out  16  mismatching headers, saturating at 16'hFFFF.
- FirstErrorValid  out  1  at least one mismatch seen.
- FirstErrorBucket  out  log2(NumBuckets+1)  index of the first mismatching bucket.

Behaviour:
- Reset (async, Reset=0):
  - State=RUN, so the block autostarts like the writer.
  - All counters 0; DRAMCommandValid=0 for the first cycle after release.
  - DRAMReadDataReady=0; Done=0; Pass=0; ErrorCount=0; FirstErrorValid=0; FirstErrorBucket=0.
- States:
  - RUN: issue reads and check returned data.
  - DONE: Done=1, all counters frozen.
  - IDLE: not reachable from reset; reserved.
  - RUN -> DONE when checked count == NumBuckets.
  - DONE + Start -> RUN, clearing counters, ErrorCount, FirstError* and Done on the next edge.
- Command side:
  - CmdCnt counts bucket indices.
  - DRAMCommandAddress = CmdCnt*BktSize_DRWords, a registered value stepped by BktSize_DRWords on each handshake.
  - DRAMCommandValid = RUN & (CmdCnt != NumBuckets) & (Outstanding < MaxOutstanding).
  - Address and command stay stable while Valid & ~Ready.
- Outstanding counter:
  - +1 on command handshake, -1 on the last beat of a header.
  - Both in the same cycle: unchanged.
  - Never exceeds MaxOutstanding and never underflows.
  - A data beat arriving with Outstanding==0 is accepted and dropped; no counter changes.
- Read side:
  - DRAMReadDataReady = RUN after the first post-reset cycle.
  - Beats = DDRDWidth/BEDWidth (1 if BEDWidth >= DDRDWidth).
  - Beat k fills header bits [k*BEDWidth +: BEDWidth], LSB chunk first, matching the writer's reversed shift-out.
  - Beat counter wraps Beats-1 -> 0.
  - Check happens on the last beat, using the combinational merge of the held beats and the current beat; latency 1 cycle to the error registers.
- Check rule:
  - Mismatch if IV field != IVInit or valid field != 0.
  - Bits above IVWidth+ValidBits are don't-care.
  - On mismatch: ErrorCount++ (saturating).
  - On the first mismatch only: FirstErrorBucket = ChkCnt, FirstErrorValid=1.
  - ChkCnt++ on every completed header; data returns in command order.
- Done timing:
  - Done asserts the cycle after ChkCnt reaches NumBuckets; Pass=Done & (ErrorCount==0).
  - NumBuckets==0 means Done one cycle after reset release.
- Reset mid-pass: everything returns to reset values immediately. In-flight DRAM responses after reset release are dropped per the Outstanding==0 rule.

Decomposition:
- Shared package: DDR3 command encodings (DDR3CMD_Read/Write), IVInit default, header field offsets (IV, valid, space), BktSize_DRWords, and the NumBuckets formula (2^(L+1) + number of subtrees).
- One sub-module, hdr_beat_assembler: beat counter plus shift/hold register producing HeaderValid/Header from BEDWidth beats.

Test Plan:
- All 16 buckets (NumBuckets=16, BktSize_DRWords=8) return IV=0, valid=0, Ready always 1 -> addresses 0,8,...,120 issued once each; Done=1, Pass=1, ErrorCount=0.
- Bucket 5 returns valid field 4'b0010 and bucket 9 returns a wrong IV -> ErrorCount=2, FirstErrorValid=1, FirstErrorBucket=5, Pass=0.
- Memory model withholds read data and DRAMCommandReady=1 -> exactly 8 commands issued, then Valid=0. After one header returns, exactly one more command is issued.
- DRAMCommandReady toggled randomly, 4 beats per header with random valid gaps -> address stable under backpressure, no lost or duplicated checks, Done after 16 headers.
- Reset pulsed low while 5 reads are outstanding -> outputs return to reset values asynchronously; stale beats dropped; the rerun passes with addresses starting at 0.
- In DONE, pulse Start with bucket 3 corrupted in the model -> counters clear; second pass reports ErrorCount=1, FirstErrorBucket=3.
